// File: rtl/ins_fetcher.sv
// Instruction fetcher: single-outstanding I-cache requester feeding a QUEUE_SIZE-deep instruction queue.
// Latency: response strobe to ins_valid_out one cycle; request issued the cycle after IDLE with room.
// Backpressure: no request while the queue is full; rdy_in low freezes all state. Option: JAL_PREDICT_EN.
module ins_fetcher #(
  parameter int QUEUE_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic [31:0] clear_pc_in,
  output logic        icache_req_out,
  output logic [31:0] icache_addr_out,
  input  logic        icache_valid_in,
  input  logic [31:0] icache_ins_in,
  input  logic        issue_en_in,
  output logic        ins_valid_out,
  output logic [31:0] ins_code_out,
  output logic [31:0] ins_pc_out,
  output logic [31:0] ins_pred_pc_out
);

  localparam int AW = $clog2(QUEUE_SIZE);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QUEUE_SIZE);

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic [31:0] pred_pc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt, next_pc;
  logic          req_nxt;
  logic [31:0]   addr_nxt;
  logic          push, pop;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  entry_t        queue [QUEUE_SIZE];
  entry_t        head_ent;

`ifdef JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm = {{11{icache_ins_in[31]}}, icache_ins_in[31], icache_ins_in[19:12],
                    icache_ins_in[20], icache_ins_in[30:21], 1'b0};
  assign next_pc = (icache_ins_in[6:0] == 7'h6F) ? fetch_pc + jal_imm : fetch_pc + 32'd4;
`else
  assign next_pc = fetch_pc + 32'd4;
`endif

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_nxt      = icache_req_out;
    addr_nxt     = icache_addr_out;
    push         = 1'b0;
    pop          = 1'b0;
    if (clear_in) begin
      fetch_pc_nxt = clear_pc_in;
      req_nxt      = 1'b0;
      // A response still owed by the cache must be swallowed before fetching again.
      state_nxt    = ((state != IDLE) && !icache_valid_in) ? DISCARD : IDLE;
    end else begin
      pop = issue_en_in && (count != '0);
      case (state)
        IDLE: begin
          if (count != FULL_CNT) begin
            state_nxt = WAIT;
            req_nxt   = 1'b1;
            addr_nxt  = fetch_pc;
          end
        end
        WAIT: begin
          if (icache_valid_in) begin
            push         = 1'b1;
            fetch_pc_nxt = next_pc;
            req_nxt      = 1'b0;
            state_nxt    = IDLE;
          end
        end
        DISCARD: begin
          if (icache_valid_in) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      fetch_pc        <= '0;
      icache_req_out  <= 1'b0;
      icache_addr_out <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
    end else if (rdy_in) begin
      state           <= state_nxt;
      fetch_pc        <= fetch_pc_nxt;
      icache_req_out  <= req_nxt;
      icache_addr_out <= addr_nxt;
      if (clear_in) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (pop)  head <= head + 1'b1;
        if (push) tail <= tail + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset; count gates visibility of every slot.
  always_ff @(posedge clk_in) begin
    if (rdy_in && push) queue[tail] <= '{code: icache_ins_in, pc: fetch_pc, pred_pc: next_pc};
  end

  assign head_ent        = queue[head];
  assign ins_valid_out   = (count != '0);
  assign ins_code_out    = head_ent.code;
  assign ins_pc_out      = head_ent.pc;
  assign ins_pred_pc_out = head_ent.pred_pc;

endmodule
